// File: rtl/anubis_uart_tx_pkg.sv
// rtl/anubis_uart_tx_pkg.sv - shared block geometry and FSM encoding for the Anubis UART transmitter
package anubis_uart_tx_pkg;
   localparam int ANUBIS_BLOCK_W = 128;
   localparam int BLOCK_BYTES    = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;
endpackage

// File: rtl/anubis_uart_tx_if.sv
// rtl/anubis_uart_tx_if.sv - block handover handshake between cipher core and UART transmitter
interface anubis_uart_tx_if;
   import anubis_uart_tx_pkg::*;

   logic [ANUBIS_BLOCK_W-1:0] blk_data;
   logic                      blk_valid;
   logic                      blk_ready;

   modport master (output blk_data, output blk_valid, input blk_ready);
   modport slave  (input blk_data, input blk_valid, output blk_ready);
endinterface

// File: rtl/anubis_uart_tx_tick_sync.sv
// rtl/anubis_uart_tx_tick_sync.sv - synchronises the divided clock and emits one tick per rising edge
module anubis_uart_tx_tick_sync (
   input  logic clk_w5,
   input  logic reset_b,
   input  logic clk_div,
   output logic tick
);
   // [0],[1] form the synchroniser; [2] holds the previous synchronised level
   logic [2:0] sync_q;

   always_ff @(posedge clk_w5 or posedge reset_b) begin
      if (reset_b) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], clk_div};
      end
   end

   assign tick = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/anubis_uart_tx.sv
// rtl/anubis_uart_tx.sv - sends one 128-bit Anubis block as 16 UART 8N1 bytes, timed by clk_div ticks
module anubis_uart_tx
   import anubis_uart_tx_pkg::*;
#(
   parameter int TICKS_PER_BIT = 17,
   parameter int STOP_BITS     = 1
) (
   input  logic            clk_w5,
   input  logic            reset_b,
   input  logic            clk_div,
   anubis_uart_tx_if.slave blk,
   output logic            tx,
   output logic            busy,
   output logic            byte_done
);
   localparam int              TC_W      = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam logic [TC_W-1:0] TC_LAST   = TC_W'(TICKS_PER_BIT - 1);
   localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [3:0]      BYTE_LAST = 4'(BLOCK_BYTES - 1);

   tx_state_t                 state, state_n;
   logic [TC_W-1:0]           tc, tc_n;
   logic [2:0]                bit_cnt, bit_n;
   logic [3:0]                byte_cnt, byte_n;
   logic [ANUBIS_BLOCK_W-1:0] shreg, sh_n;
   logic [7:0]                cur_byte;
   logic                      tx_n;
   logic                      done_n;
   logic                      tick;
   logic                      bit_end;

   anubis_uart_tx_tick_sync u_tick_sync (
      .clk_w5  (clk_w5),
      .reset_b (reset_b),
      .clk_div (clk_div),
      .tick    (tick)
   );

   assign bit_end         = tick && (tc == TC_LAST);
   assign cur_byte        = sh_n[ANUBIS_BLOCK_W-1 -: 8];
   assign blk.blk_ready   = (state == ST_IDLE);
   assign busy            = (state != ST_IDLE);

   always_ff @(posedge clk_w5 or posedge reset_b) begin
      if (reset_b) begin
         state     <= ST_IDLE;
         tc        <= '0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         shreg     <= '0;
         tx        <= 1'b1;
         byte_done <= 1'b0;
      end else begin
         state     <= state_n;
         tc        <= tc_n;
         bit_cnt   <= bit_n;
         byte_cnt  <= byte_n;
         shreg     <= sh_n;
         tx        <= tx_n;
         byte_done <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      tc_n    = tc;
      bit_n   = bit_cnt;
      byte_n  = byte_cnt;
      sh_n    = shreg;
      done_n  = 1'b0;

      // IDLE ignores ticks, so a tick landing on the transfer cycle never advances tc
      if (state != ST_IDLE && tick) begin
         tc_n = bit_end ? '0 : tc + TC_W'(1);
      end

      case (state)
         ST_IDLE: begin
            if (blk.blk_valid) begin
               state_n = ST_START;
               tc_n    = '0;
               bit_n   = '0;
               byte_n  = '0;
               sh_n    = blk.blk_data;
            end
         end
         ST_START: begin
            if (bit_end) state_n = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end) begin
               bit_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  sh_n    = shreg << 8;
                  state_n = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            // bit_cnt is reused to count stop bits
            if (bit_end) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_n  = '0;
                  done_n = 1'b1;
                  if (byte_cnt == BYTE_LAST) begin
                     state_n = ST_IDLE;
                  end else begin
                     byte_n  = byte_cnt + 4'd1;
                     state_n = ST_START;
                  end
               end else begin
                  bit_n = bit_cnt + 3'd1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // line level is decided from the next state so the pin comes straight off a flop
      case (state_n)
         ST_START: tx_n = 1'b0;
         ST_DATA:  tx_n = cur_byte[bit_n];
         default:  tx_n = 1'b1;
      endcase
   end
endmodule
